fft_radix2_iter: RTL
====================

Name: fft_radix2_iter

Overview:
- Iterative, in-place, radix-2 decimation-in-time FFT/IFFT engine over N complex signed fixed-point samples.
- Successor to the fixed 64-point butterfly block: parametrised point count, data width and twiddle width.
- Adds an explicit start/busy/done handshake, an inverse mode, optional per-stage scaling and output saturation.
- Sits between the sample-capture front end and the spectral post-processing; performs one butterfly per clock.

Parameters:
- N_POINTS, 64, transform length; power of two, 4..1024.
- LOG2_N, 6, log2(N_POINTS); a mismatch with N_POINTS is an elaboration error.
- D_WIDTH, 16, signed sample width (two's complement).
- TW_WIDTH, 10, signed twiddle width. Format Q1.(TW_WIDTH-2), so 1.0 = 2^(TW_WIDTH-2) = 256.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a transform; sampled only when idle.
- inverse  in  1  0 = forward transform, 1 = inverse transform (conjugated twiddles); latched at start.
- scale_en  in  1  1 = arithmetic shift right by 1 after every stage; latched at start.
- in_re  in  N_POINTS x D_WIDTH  real input samples, natural order.
- in_im  in  N_POINTS x D_WIDTH  imaginary input samples, natural order.
- busy  out  1  high while the transform runs.
- done  out  1  one-cycle pulse when results are final.
- out_re  out  N_POINTS x D_WIDTH  real results, natural frequency order; direct view of the working registers.
- out_im  out  N_POINTS x D_WIDTH  imaginary results, natural frequency order; direct view of the working registers.

Behaviour:
- Reset (rst=0, any time, including mid-transform):
  - State goes to IDLE.
  - busy=0, done=0.
  - All working registers = 0, so out_re and out_im read 0.
  - Stage and butterfly counters = 0; latched mode bits = 0.
- States: IDLE, RUN.
  - IDLE -> RUN on a rising edge with start=1. On that edge (E0):
    - in[n] is written into working register bitrev(n), using LOG2_N-bit reversal.
    - inverse and scale_en are latched.
    - busy goes to 1.
  - RUN performs one butterfly per edge, E1..E(N/2*LOG2_N), which is 192 edges at the defaults.
  - On the final butterfly edge: busy goes to 0, done goes to 1, state returns to IDLE.
  - done goes to 0 on the next edge.
- start while busy=1 is ignored: no restart, no reload.
- start on the same edge that done rises is ignored; the engine is idle from the following edge.
- Butterfly addressing, for stage s = 0..LOG2_N-1 and butterfly index b = 0..N/2-1 (b increments; it wraps to 0 and s increments after N/2-1):
  - span = 2^s
  - pos = b mod span
  - top = (b >> s) * 2 * span + pos
  - bot = top + span
  - twiddle index k = pos << (LOG2_N-1-s)
- Twiddle source: an internal constant table for k = 0..N/2-1.
  - Wr = round(cos(2*pi*k/N) * 2^(TW_WIDTH-2)), round-half-away-from-zero.
  - Wi = -round(sin(2*pi*k/N) * 2^(TW_WIDTH-2)) for forward; +round(...) for inverse.
  - Table generated at elaboration; no external ROM.
- Arithmetic per butterfly, with A = x[top] and B = x[bot]:
  - Full-precision complex product P = W * B, width D_WIDTH+TW_WIDTH+1.
  - t = (P + 2^(TW_WIDTH-3)) >>> (TW_WIDTH-2), i.e. round half up.
  - x[top] = A + t and x[bot] = A - t, computed at D_WIDTH+2 bits.
  - If the latched scale_en = 1, both results are then arithmetic-shifted right by 1 (floor).
  - Each result is then saturated to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
  - Both locations are updated on the same edge. No other register changes during RUN.
- After done: out_re and out_im hold the final results until the next accepted start or reset.
- Outputs are intermediate, and not meaningful, while busy=1.
- Inverse mode does no 1/N normalisation; use scale_en=1 to obtain it.

Test Plan:
1. Impulse: in_re[0]=1000, all other inputs 0, forward, scale_en=0, start pulse.
   - busy is high for exactly 192 edges; done pulses once.
   - All out_re = 1000 and all out_im = 0.
2. DC: all in_re = 100, in_im = 0, forward, scale_en=1.
   - out_re[0] = 100; all other bins = 0 (both re and im).
3. Nyquist: in_re[n] = 256*(-1)^n, forward, scale_en=1.
   - out_re[32] = 256; all other bins = 0 (both re and im).
4. Saturation: all in_re = 20000, forward, scale_en=0.
   - out_re[0] = 32767.
   - All other bins are 0 ±1 LSB.
   - No wraparound to negative values.
5. Round trip on a random vector:
   - Run forward with scale_en=1, feed the results back with inverse=1 and scale_en=0.
   - The recovered samples equal the originals within ±4 LSB.
6. Handshake and reset:
   - A start pulse at edge 50 of a run is ignored; done still occurs at edge 192.
   - With N_POINTS=16 and LOG2_N=4, done occurs at edge 32.
   - Asserting rst at edge 100 clears busy, done and all outputs to 0 immediately (asynchronously).
   - A following start runs cleanly.

Source files
------------

// File: rtl/fft_radix2_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_radix2_iter_if
//  Description : Control handshake and sample/result buses of the iterative
//                radix-2 FFT engine. The master drives start, mode bits and
//                the input samples. The slave (the engine) returns busy/done
//                and exposes its working registers as results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_radix2_iter_if #(
    parameter int N_POINTS = 64,
    parameter int D_WIDTH  = 16
);
    logic                             start;
    logic                             inverse;
    logic                             scale_en;
    logic [N_POINTS-1:0][D_WIDTH-1:0] in_re;
    logic [N_POINTS-1:0][D_WIDTH-1:0] in_im;
    logic                             busy;
    logic                             done;
    logic [N_POINTS-1:0][D_WIDTH-1:0] out_re;
    logic [N_POINTS-1:0][D_WIDTH-1:0] out_im;

    modport master (
        output start, inverse, scale_en, in_re, in_im,
        input  busy, done, out_re, out_im
    );

    modport slave (
        input  start, inverse, scale_en, in_re, in_im,
        output busy, done, out_re, out_im
    );
endinterface
`default_nettype wire

// File: rtl/fft_radix2_iter.sv
`default_nettype none
// ============================================================================
//  Module      : fft_radix2_iter
//  Description : Iterative in-place radix-2 decimation-in-time FFT/IFFT.
//                Samples are loaded in bit-reversed order when a transform
//                starts, then one butterfly is evaluated per clock until all
//                LOG2_N stages are complete. Inverse mode conjugates the
//                twiddles; optional per-stage halving and output saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_radix2_iter #(
    parameter int N_POINTS = 64,
    parameter int LOG2_N   = 6,
    parameter int D_WIDTH  = 16,
    parameter int TW_WIDTH = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fft_radix2_iter_if.slave bus
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_AW     = LOG2_N;                  // sample address
    localparam int c_BW     = LOG2_N - 1;              // butterfly index / twiddle index
    localparam int c_SW     = $clog2(LOG2_N);          // stage counter
    localparam int c_HALF_N = N_POINTS / 2;
    localparam int c_FRAC   = TW_WIDTH - 2;            // twiddle fraction bits
    localparam int c_PW     = D_WIDTH + TW_WIDTH + 1;  // full-precision product

    localparam logic [c_SW-1:0]        c_LAST_STAGE = c_SW'(LOG2_N - 1);
    localparam logic signed [c_PW-1:0] c_RND        = c_PW'(2 ** (TW_WIDTH - 3));
    localparam logic signed [c_PW-1:0] c_MAX        = c_PW'(2 ** (D_WIDTH - 1) - 1);
    localparam logic signed [c_PW-1:0] c_MIN        = c_PW'(-(2 ** (D_WIDTH - 1)));

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // Reject an inconsistent point count at elaboration.
    generate
        if (N_POINTS != (2 ** LOG2_N) || LOG2_N < 2 || LOG2_N > 10) begin : g_param_error
            $error("fft_radix2_iter: N_POINTS must equal 2**LOG2_N and lie in 4..1024");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Twiddle table: round-half-away-from-zero of cos/sin scaled to Q1.FRAC.
    // Only the magnitude of sin is stored; its sign is applied per mode.
    // ------------------------------------------------------------------------
    localparam real c_PI  = 3.14159265358979323846;
    localparam real c_ONE = 2.0 ** c_FRAC;

    logic signed [TW_WIDTH-1:0] w_cos_tab [c_HALF_N];
    logic signed [TW_WIDTH-1:0] w_sin_tab [c_HALF_N];

    generate
        for (genvar k = 0; k < c_HALF_N; k++) begin : g_twiddle
            localparam real c_ANG   = 2.0 * c_PI * k / N_POINTS;
            localparam real c_COS   = $cos(c_ANG) * c_ONE;
            localparam real c_SIN   = $sin(c_ANG) * c_ONE;
            localparam int  c_COS_I = (c_COS >= 0.0) ? $rtoi(c_COS + 0.5) : -$rtoi(0.5 - c_COS);
            localparam int  c_SIN_I = (c_SIN >= 0.0) ? $rtoi(c_SIN + 0.5) : -$rtoi(0.5 - c_SIN);
            assign w_cos_tab[k] = TW_WIDTH'(c_COS_I);
            assign w_sin_tab[k] = TW_WIDTH'(c_SIN_I);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [c_AW-1:0] bitrev(input logic [c_AW-1:0] v);
        logic [c_AW-1:0] r;
        for (int i = 0; i < c_AW; i++) begin
            r[i] = v[c_AW-1-i];
        end
        return r;
    endfunction

    function automatic logic [D_WIDTH-1:0] sat(input logic signed [c_PW-1:0] v);
        if (v > c_MAX) begin
            return {1'b0, {(D_WIDTH-1){1'b1}}};
        end else if (v < c_MIN) begin
            return {1'b1, {(D_WIDTH-1){1'b0}}};
        end
        return v[D_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]                       r_state;
    logic                             r_done;
    logic [c_SW-1:0]                  r_stage;
    logic [c_BW-1:0]                  r_bfly;
    logic                             r_inverse;
    logic                             r_scale;
    logic [N_POINTS-1:0][D_WIDTH-1:0] r_re;
    logic [N_POINTS-1:0][D_WIDTH-1:0] r_im;

    // ------------------------------------------------------------------------
    // Butterfly addressing. The mask selects the low 'stage' bits of the
    // butterfly index; clearing them and shifting left by one gives the group
    // base, and the bottom operand sits one span above the top operand.
    // ------------------------------------------------------------------------
    logic [c_BW-1:0] w_mask;
    logic [c_BW-1:0] w_pos;
    logic [c_BW-1:0] w_k;
    logic [c_AW-1:0] w_span;
    logic [c_AW-1:0] w_top;
    logic [c_AW-1:0] w_bot;
    logic            w_last;

    assign w_mask = ~({c_BW{1'b1}} << r_stage);
    assign w_pos  = r_bfly & w_mask;
    assign w_span = {{(c_AW-1){1'b0}}, 1'b1} << r_stage;
    assign w_top  = {r_bfly & ~w_mask, 1'b0} | {1'b0, w_pos};
    assign w_bot  = w_top | w_span;
    assign w_k    = w_pos << (c_LAST_STAGE - r_stage);
    assign w_last = (r_stage == c_LAST_STAGE) && (&r_bfly);

    // ------------------------------------------------------------------------
    // Butterfly arithmetic
    // ------------------------------------------------------------------------
    logic signed [TW_WIDTH-1:0] w_wr;
    logic signed [TW_WIDTH-1:0] w_wi;
    logic signed [D_WIDTH-1:0]  w_a_re;
    logic signed [D_WIDTH-1:0]  w_a_im;
    logic signed [D_WIDTH-1:0]  w_b_re;
    logic signed [D_WIDTH-1:0]  w_b_im;
    logic signed [c_PW-1:0]     w_p_re;
    logic signed [c_PW-1:0]     w_p_im;
    logic signed [c_PW-1:0]     w_t_re;
    logic signed [c_PW-1:0]     w_t_im;
    logic signed [c_PW-1:0]     w_sum_re;
    logic signed [c_PW-1:0]     w_sum_im;
    logic signed [c_PW-1:0]     w_dif_re;
    logic signed [c_PW-1:0]     w_dif_im;
    logic signed [c_PW-1:0]     w_top_re;
    logic signed [c_PW-1:0]     w_top_im;
    logic signed [c_PW-1:0]     w_bot_re;
    logic signed [c_PW-1:0]     w_bot_im;

    // Forward uses W = cos - j*sin, inverse the conjugate.
    assign w_wr = w_cos_tab[w_k];
    assign w_wi = r_inverse ? w_sin_tab[w_k] : -w_sin_tab[w_k];

    assign w_a_re = r_re[w_top];
    assign w_a_im = r_im[w_top];
    assign w_b_re = r_re[w_bot];
    assign w_b_im = r_im[w_bot];

    assign w_p_re = c_PW'(w_wr) * c_PW'(w_b_re) - c_PW'(w_wi) * c_PW'(w_b_im);
    assign w_p_im = c_PW'(w_wr) * c_PW'(w_b_im) + c_PW'(w_wi) * c_PW'(w_b_re);

    // Round half up back to sample scale.
    assign w_t_re = (w_p_re + c_RND) >>> c_FRAC;
    assign w_t_im = (w_p_im + c_RND) >>> c_FRAC;

    assign w_sum_re = c_PW'(w_a_re) + w_t_re;
    assign w_sum_im = c_PW'(w_a_im) + w_t_im;
    assign w_dif_re = c_PW'(w_a_re) - w_t_re;
    assign w_dif_im = c_PW'(w_a_im) - w_t_im;

    // Optional halving (floor) before saturation keeps stage growth bounded.
    assign w_top_re = r_scale ? (w_sum_re >>> 1) : w_sum_re;
    assign w_top_im = r_scale ? (w_sum_im >>> 1) : w_sum_im;
    assign w_bot_re = r_scale ? (w_dif_re >>> 1) : w_dif_re;
    assign w_bot_im = r_scale ? (w_dif_im >>> 1) : w_dif_im;

    // Sequencer: idle/run state, stage and butterfly counters, latched modes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_done    <= 1'b0;
            r_stage   <= '0;
            r_bfly    <= '0;
            r_inverse <= 1'b0;
            r_scale   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_state   <= c_RUN;
                        r_stage   <= '0;
                        r_bfly    <= '0;
                        r_inverse <= bus.inverse;
                        r_scale   <= bus.scale_en;
                    end
                end
                c_RUN: begin
                    if (w_last) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                        r_stage <= '0;
                        r_bfly  <= '0;
                    end else if (&r_bfly) begin
                        r_bfly  <= '0;
                        r_stage <= r_stage + c_SW'(1);
                    end else begin
                        r_bfly  <= r_bfly + c_BW'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Working registers: bit-reversed load on start, one butterfly write-back per run cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_re <= '0;
            r_im <= '0;
        end else if (r_state == c_IDLE) begin
            if (bus.start) begin
                for (int n = 0; n < N_POINTS; n++) begin
                    r_re[bitrev(c_AW'(n))] <= bus.in_re[n];
                    r_im[bitrev(c_AW'(n))] <= bus.in_im[n];
                end
            end
        end else begin
            r_re[w_top] <= sat(w_top_re);
            r_im[w_top] <= sat(w_top_im);
            r_re[w_bot] <= sat(w_bot_re);
            r_im[w_bot] <= sat(w_bot_im);
        end
    end

    assign bus.busy   = (r_state == c_RUN);
    assign bus.done   = r_done;
    assign bus.out_re = r_re;
    assign bus.out_im = r_im;

endmodule
`default_nettype wire
